// File: rtl/amux_ctrl_pkg.sv
// Shared types and defaults for the analog-mux scan sequencer.
package amux_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_CONVERT = 2'd2,
        ST_STORE   = 2'd3
    } amux_state_t;

    localparam logic CH_AIN1 = 1'b0;
    localparam logic CH_AIN2 = 1'b1;

    localparam int DATA_W_DEF   = 10;
    localparam int SETTLE_W_DEF = 8;
    localparam int TO_W_DEF     = 12;

    function automatic int max_w(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/amux_ctrl_timer.sv
// Loadable down-counter with zero flag, shared between settle and conversion timeout.
module amux_ctrl_timer
    import amux_ctrl_pkg::*;
#(
    parameter int W = TO_W_DEF
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] count_q;

    // Load has priority; decrement saturates at zero.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_q <= count_q - W'(1'b1);
        end else begin
            count_q <= count_q;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/amux_scan_ctrl.sv
// Mux select / settle / ADC start sequencer with per-channel result capture.
module amux_scan_ctrl
    import amux_ctrl_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int SETTLE_W = SETTLE_W_DEF,
    parameter int TO_W     = TO_W_DEF
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                EN,
    input  logic                MODE,
    input  logic                CHSEL,
    input  logic [SETTLE_W-1:0] SETTLE,
    input  logic                CLR_VALID,
    input  logic                ADC_DONE,
    input  logic [DATA_W-1:0]   ADC_DATA,
    output logic                SEL,
    output logic                ADC_START,
    output logic [DATA_W-1:0]   RESULT1,
    output logic [DATA_W-1:0]   RESULT2,
    output logic                VALID1,
    output logic                VALID2,
    output logic                BUSY,
    output logic                ERR
);

    localparam int TMR_W = max_w(SETTLE_W, TO_W);
    // Zero is reached after exactly 2^TO_W-1 CONVERT cycles counted from the load.
    localparam logic [TMR_W-1:0] TO_LOAD = TMR_W'((64'd1 << TO_W) - 64'd2);

    amux_state_t       state_q, state_d;
    logic              sel_q, sel_d;
    logic              start_q, start_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;
    logic              valid1_q, valid1_d;
    logic              valid2_q, valid2_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] result1_q, result1_d;
    logic [DATA_W-1:0] result2_q, result2_d;

    logic              tmr_load_s;
    logic              tmr_dec_s;
    logic              tmr_zero_s;
    logic [TMR_W-1:0]  tmr_val_s;
    logic [TMR_W-1:0]  settle_val_s;

    assign settle_val_s = TMR_W'(SETTLE);
    assign tmr_dec_s    = (state_q == ST_SETTLE) || (state_q == ST_CONVERT);

    amux_ctrl_timer #(.W(TMR_W)) u_timer (
        .clk        (clk),
        .resetn     (resetn),
        .load_i     (tmr_load_s),
        .load_val_i (tmr_val_s),
        .dec_i      (tmr_dec_s),
        .zero_o     (tmr_zero_s)
    );

    // Next-state and output decode for the scan sequencer.
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        start_d    = 1'b0;
        data_d     = data_q;
        result1_d  = result1_q;
        result2_d  = result2_q;
        valid1_d   = CLR_VALID ? 1'b0 : valid1_q;
        valid2_d   = CLR_VALID ? 1'b0 : valid2_q;
        err_d      = CLR_VALID ? 1'b0 : err_q;
        tmr_load_s = 1'b0;
        tmr_val_s  = TO_LOAD;
        case (state_q)
            ST_IDLE: begin
                if (EN) begin
                    state_d    = ST_SETTLE;
                    sel_d      = CHSEL;
                    tmr_load_s = 1'b1;
                    tmr_val_s  = settle_val_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (!EN) begin
                    state_d = ST_IDLE;
                end else if (tmr_zero_s) begin
                    state_d    = ST_CONVERT;
                    start_d    = 1'b1;
                    tmr_load_s = 1'b1;
                    tmr_val_s  = TO_LOAD;
                end else begin
                    state_d = ST_SETTLE;
                end
            end
            ST_CONVERT: begin
                // start_q marks the first CONVERT cycle, where DONE is not trusted.
                if (ADC_DONE && !start_q) begin
                    data_d  = ADC_DATA;
                    state_d = ST_STORE;
                end else if (tmr_zero_s) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_CONVERT;
                end
            end
            ST_STORE: begin
                if (sel_q == CH_AIN1) begin
                    result1_d = data_q;
                    valid1_d  = 1'b1;
                end else begin
                    result2_d = data_q;
                    valid2_d  = 1'b1;
                end
                if (!EN) begin
                    state_d = ST_IDLE;
                end else if (MODE) begin
                    state_d    = ST_SETTLE;
                    sel_d      = ~sel_q;
                    tmr_load_s = 1'b1;
                    tmr_val_s  = settle_val_s;
                end else if (CHSEL == sel_q) begin
                    state_d    = ST_CONVERT;
                    start_d    = 1'b1;
                    tmr_load_s = 1'b1;
                    tmr_val_s  = TO_LOAD;
                end else begin
                    state_d    = ST_SETTLE;
                    sel_d      = CHSEL;
                    tmr_load_s = 1'b1;
                    tmr_val_s  = settle_val_s;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            sel_q     <= CH_AIN1;
            start_q   <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
            valid1_q  <= 1'b0;
            valid2_q  <= 1'b0;
            data_q    <= '0;
            result1_q <= '0;
            result2_q <= '0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            start_q   <= start_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
            valid1_q  <= valid1_d;
            valid2_q  <= valid2_d;
            data_q    <= data_d;
            result1_q <= result1_d;
            result2_q <= result2_d;
        end
    end

    assign SEL       = sel_q;
    assign ADC_START = start_q;
    assign BUSY      = busy_q;
    assign ERR       = err_q;
    assign VALID1    = valid1_q;
    assign VALID2    = valid2_q;
    assign RESULT1   = result1_q;
    assign RESULT2   = result2_q;

endmodule

// File: tb/tb_amux_scan_ctrl.sv
// Self-checking bench for amux_scan_ctrl: vector table + ADC model + result scoreboard.
module tb_amux_scan_ctrl;

    logic       clk, resetn, EN, MODE, CHSEL, CLR_VALID, ADC_DONE;
    logic [7:0] SETTLE;
    logic [9:0] ADC_DATA;
    logic       SEL, ADC_START, VALID1, VALID2, BUSY, ERR;
    logic [9:0] RESULT1, RESULT2;

    amux_scan_ctrl #(.DATA_W(10), .SETTLE_W(8), .TO_W(4)) dut (
        .clk(clk), .resetn(resetn), .EN(EN), .MODE(MODE), .CHSEL(CHSEL),
        .SETTLE(SETTLE), .CLR_VALID(CLR_VALID), .ADC_DONE(ADC_DONE), .ADC_DATA(ADC_DATA),
        .SEL(SEL), .ADC_START(ADC_START), .RESULT1(RESULT1), .RESULT2(RESULT2),
        .VALID1(VALID1), .VALID2(VALID2), .BUSY(BUSY), .ERR(ERR)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct { logic ch; logic [9:0] data; } sb_t;
    typedef struct {
        logic mode; logic chsel; int settle; int lat;
        logic [9:0] d1; logic [9:0] d2; logic glitch;
    } vec_t;

    sb_t  sb_q[$];
    sb_t  cur;
    vec_t vecs[5];

    int   checks = 0, failures = 0;
    int   cyc = 0, due = 0, conv_n = 0, sel_chg = 0, last_start = 0, adc_cnt = 0, steps;
    logic adc_armed = 1'b0, prev_sel = 1'b0, prev_start = 1'b0, exp_ch;
    logic [9:0] adc_val;
    logic cfg_mode, cfg_chsel, cfg_glitch, cfg_withhold;
    int   cfg_settle, cfg_lat;
    logic [9:0] cfg_d1, cfg_d2;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic budget_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=budget_expired required=event (cycle %0d)", name, cyc);
    endtask

    // One clock: scoreboard compare, ADC model, start-pulse checks.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (due != 0) begin
            due--;
            if (due == 0) begin
                if (cur.ch) begin
                    chk("sb_result2", 32'(RESULT2), 32'(cur.data));
                    chk("sb_valid2", 32'(VALID2), 32'd1);
                end else begin
                    chk("sb_result1", 32'(RESULT1), 32'(cur.data));
                    chk("sb_valid1", 32'(VALID1), 32'd1);
                end
            end
        end
        if (conv_n > 0 && SEL != prev_sel) sel_chg++;
        ADC_DONE = 1'b0;
        if (adc_armed) begin
            if (adc_cnt == 1) begin
                ADC_DONE  = 1'b1;
                ADC_DATA  = adc_val;
                adc_armed = 1'b0;
                if (sb_q.size() != 0) begin
                    cur = sb_q.pop_front();
                    due = 2;
                end
            end else begin
                adc_cnt--;
            end
        end
        if (ADC_START) begin
            exp_ch = cfg_mode ? (cfg_chsel ^ conv_n[0]) : cfg_chsel;
            chk("start_sel", 32'(SEL), 32'(exp_ch));
            chk("start_sel_stable", 32'(SEL), 32'(prev_sel));
            chk("start_single", 32'(prev_start), 32'd0);
            if (conv_n != 0)
                chk("start_period", 32'(cyc - last_start),
                    32'(cfg_mode ? cfg_settle + 3 + cfg_lat : cfg_lat + 2));
            last_start = cyc;
            conv_n++;
            adc_val = exp_ch ? cfg_d2 : cfg_d1;
            if (!cfg_withhold) begin
                adc_armed = 1'b1;
                adc_cnt   = cfg_lat;
                sb_q.push_back(sb_t'{exp_ch, adc_val});
            end
            if (cfg_glitch) begin
                ADC_DONE = 1'b1;
                ADC_DATA = ~adc_val;
            end
        end
        prev_sel   = SEL;
        prev_start = ADC_START;
    endtask

    task automatic do_reset();
        resetn = 1'b0; EN = 1'b0; CLR_VALID = 1'b0;
        step();
        step();
        resetn = 1'b1;
        sb_q.delete();
        due = 0;
        adc_armed = 1'b0;
    endtask

    task automatic configure(input logic m, input logic c, input int s, input int l,
                             input logic [9:0] a, input logic [9:0] b, input logic g, input logic w);
        cfg_mode = m; cfg_chsel = c; cfg_settle = s; cfg_lat = l;
        cfg_d1 = a; cfg_d2 = b; cfg_glitch = g; cfg_withhold = w;
        MODE = m; CHSEL = c; SETTLE = s[7:0];
        conv_n = 0; sel_chg = 0;
    endtask

    task automatic wait_conv(input int n, input string name);
        steps = 0;
        while (conv_n < n && steps < 300) begin
            step();
            steps++;
        end
        if (conv_n < n) budget_fail(name);
    endtask

    task automatic wait_idle(input string name);
        steps = 0;
        while ((BUSY || due != 0) && steps < 200) begin
            step();
            steps++;
        end
        if (BUSY || due != 0) budget_fail(name);
    endtask

    initial begin
        resetn = 1'b0; EN = 1'b0; MODE = 1'b0; CHSEL = 1'b0; SETTLE = 8'd0;
        CLR_VALID = 1'b0; ADC_DONE = 1'b0; ADC_DATA = 10'h000;
        configure(1'b0, 1'b0, 0, 1, 10'h000, 10'h000, 1'b0, 1'b0);

        vecs[0] = '{mode: 1'b0, chsel: 1'b1, settle: 4, lat: 6, d1: 10'h155, d2: 10'h2A5, glitch: 1'b0};
        vecs[1] = '{mode: 1'b1, chsel: 1'b0, settle: 0, lat: 3, d1: 10'h011, d2: 10'h3FF, glitch: 1'b0};
        vecs[2] = '{mode: 1'b1, chsel: 1'b1, settle: 2, lat: 1, d1: 10'h155, d2: 10'h0AA, glitch: 1'b1};
        vecs[3] = '{mode: 1'b0, chsel: 1'b0, settle: 0, lat: 2, d1: 10'h3FF, d2: 10'h001, glitch: 1'b0};
        vecs[4] = '{mode: 1'b0, chsel: 1'b0, settle: 7, lat: 5, d1: 10'h0C3, d2: 10'h222, glitch: 1'b1};

        do_reset();
        chk("rst_sel", 32'(SEL), 32'd0);
        chk("rst_start", 32'(ADC_START), 32'd0);
        chk("rst_result1", 32'(RESULT1), 32'd0);
        chk("rst_result2", 32'(RESULT2), 32'd0);
        chk("rst_valid", 32'({VALID1, VALID2}), 32'd0);
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_err", 32'(ERR), 32'd0);

        for (int v = 0; v < 5; v++) begin
            do_reset();
            configure(vecs[v].mode, vecs[v].chsel, vecs[v].settle, vecs[v].lat,
                      vecs[v].d1, vecs[v].d2, vecs[v].glitch, 1'b0);
            EN = 1'b1;
            step();
            chk("en_sel", 32'(SEL), 32'(vecs[v].chsel));
            chk("en_busy", 32'(BUSY), 32'd1);
            wait_conv(1, "first_start");
            chk("start_latency", 32'(steps + 1), 32'(vecs[v].settle + 2));
            wait_conv(4, "four_convs");
            EN = 1'b0;
            wait_idle("vec_idle");
            chk("sb_drained", 32'(sb_q.size()), 32'd0);
            chk("vec_err", 32'(ERR), 32'd0);
            chk("sel_toggles", 32'(sel_chg), vecs[v].mode ? 32'd3 : 32'd0);
            if (!vecs[v].mode)
                chk("unused_result", vecs[v].chsel ? 32'(RESULT1) : 32'(RESULT2), 32'd0);
        end

        // EN dropped mid-SETTLE: abort, SEL holds, no start.
        do_reset();
        configure(1'b0, 1'b1, 5, 3, 10'h111, 10'h222, 1'b0, 1'b0);
        EN = 1'b1;
        step();
        step();
        step();
        EN = 1'b0;
        step();
        chk("abort_busy", 32'(BUSY), 32'd0);
        chk("abort_sel", 32'(SEL), 32'd1);
        chk("abort_start", 32'(ADC_START), 32'd0);
        repeat (10) step();
        chk("abort_no_conv", 32'(conv_n), 32'd0);

        // EN dropped mid-CONVERT: result still stored, then IDLE.
        configure(1'b0, 1'b0, 0, 4, 10'h1C3, 10'h2BC, 1'b0, 1'b0);
        EN = 1'b1;
        wait_conv(1, "conv_drop_start");
        EN = 1'b0;
        wait_idle("conv_drop_idle");
        chk("conv_drop_count", 32'(conv_n), 32'd1);
        chk("conv_drop_sel", 32'(SEL), 32'd0);
        chk("conv_drop_r1", 32'(RESULT1), 32'h1C3);

        // Timeout: no DONE for 15 CONVERT cycles.
        configure(1'b0, 1'b0, 1, 3, 10'h0FF, 10'h0FF, 1'b0, 1'b1);
        EN = 1'b1;
        wait_conv(1, "to_start");
        EN = 1'b0;
        repeat (14) step();
        chk("to_err_early", 32'(ERR), 32'd0);
        chk("to_busy_early", 32'(BUSY), 32'd1);
        step();
        chk("to_err", 32'(ERR), 32'd1);
        chk("to_busy", 32'(BUSY), 32'd0);
        chk("to_r1_kept", 32'(RESULT1), 32'h1C3);
        chk("to_valid_kept", 32'({VALID1, VALID2}), 32'b10);
        chk("to_r2_kept", 32'(RESULT2), 32'd0);
        CLR_VALID = 1'b1;
        step();
        CLR_VALID = 1'b0;
        chk("clr_err", 32'(ERR), 32'd0);
        chk("clr_valid1", 32'(VALID1), 32'd0);
        chk("clr_r1_kept", 32'(RESULT1), 32'h1C3);

        // CLR_VALID on the STORE edge of a ch2 result with VALID1 set.
        configure(1'b1, 1'b0, 0, 2, 10'h0F0, 10'h30F, 1'b0, 1'b0);
        EN = 1'b1;
        steps = 0;
        while (!(conv_n == 2 && due == 1) && steps < 100) begin
            step();
            steps++;
        end
        if (!(conv_n == 2 && due == 1)) budget_fail("clr_store_wait");
        chk("clr_store_pre_v1", 32'(VALID1), 32'd1);
        CLR_VALID = 1'b1;
        EN = 1'b0;
        step();
        CLR_VALID = 1'b0;
        chk("clr_store_flags", 32'({VALID1, VALID2}), 32'b01);
        wait_idle("clr_store_idle");

        // resetn low mid-CONVERT; the in-flight DONE must be ignored.
        configure(1'b0, 1'b1, 1, 5, 10'h3AB, 10'h3AB, 1'b0, 1'b0);
        EN = 1'b1;
        wait_conv(1, "rst_conv_start");
        step();
        step();
        resetn = 1'b0;
        EN = 1'b0;
        step();
        chk("midrst_outs", 32'({SEL, ADC_START, VALID1, VALID2, BUSY, ERR}), 32'd0);
        chk("midrst_results", 32'({RESULT1, RESULT2}), 32'd0);
        resetn = 1'b1;
        sb_q.delete();
        due = 0;
        repeat (8) step();
        chk("midrst_done_ignored", 32'({RESULT2, VALID2}), 32'd0);
        chk("midrst_idle", 32'(BUSY), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
